// File: rtl/ahb_lite_sdram_pkg.sv
// Shared definitions for the multi-port AHB-Lite front end of the SDRAM controller.
package ahb_lite_sdram_pkg;

    // AHB-Lite transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB-Lite transfer sizes supported by the SDRAM path
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Command word is {write, be[3:0], waddr}; offsets are relative to the
    // first bit above the word address field.
    localparam int unsigned CMD_BE_OFS    = 0;
    localparam int unsigned CMD_BE_W      = 4;
    localparam int unsigned CMD_WRITE_OFS = 4;
    localparam int unsigned CMD_CTRL_W    = 5;

    // Per-port transfer state
    typedef enum logic [2:0] {
        PS_IDLE,
        PS_REQ,
        PS_RWAIT,
        PS_DONE,
        PS_ERR1,
        PS_ERR2
    } port_state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] be;
    } be_info_t;

    // Byte lanes touched by a transfer, plus whether size/alignment is legal.
    function automatic be_info_t be_decode(input logic [2:0] size, input logic [1:0] a);
        be_info_t r;
        r.legal = 1'b0;
        r.be    = '0;
        case (size)
            HSIZE_BYTE: begin
                r.legal = 1'b1;
                r.be    = 4'b0001 << a;
            end
            HSIZE_HALF: begin
                r.legal = ~a[0];
                r.be    = 4'b0011 << a;
            end
            HSIZE_WORD: begin
                r.legal = (a == 2'b00);
                r.be    = 4'b1111;
            end
            default: begin
                r.legal = 1'b0;
                r.be    = '0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_lite_sdram_port.sv
// One AHB-Lite slave port: address-phase capture, transfer FSM and read-data register.
module ahb_lite_sdram_port
    import ahb_lite_sdram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic                  hwrite,
    input  logic                  hready,
    input  logic                  push,
    input  logic                  pop,
    input  logic [31:0]           rdata,
    output logic [31:0]           hrdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic                  req,
    output logic                  req_write,
    output logic [3:0]            req_be,
    output logic [ADDR_WIDTH-1:0] req_waddr
);

    port_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  write_q, write_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic                  cap;
    be_info_t              be_chk;

    // Upper address bits lie outside the SDRAM word space
    if (ADDR_WIDTH < 30) begin : g_unused_addr
        logic unused_haddr;
        always_comb unused_haddr = ^haddr[31:ADDR_WIDTH+2];
    end

    // Next-state, capture and bus response for this port
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        write_d   = write_q;
        be_d      = be_q;
        hrdata_d  = hrdata_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        cap       = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
        be_chk    = be_decode(hsize, haddr[1:0]);
        case (state_q)
            PS_IDLE, PS_DONE: begin
                if (cap) begin
                    waddr_d = haddr[ADDR_WIDTH+1:2];
                    write_d = hwrite;
                    be_d    = be_chk.be;
                    state_d = be_chk.legal ? PS_REQ : PS_ERR1;
                end else begin
                    state_d = PS_IDLE;
                end
            end
            PS_REQ: begin
                hreadyout = 1'b0;
                if (push) begin
                    state_d = write_q ? PS_DONE : PS_RWAIT;
                end
            end
            PS_RWAIT: begin
                hreadyout = 1'b0;
                if (pop) begin
                    hrdata_d = rdata;
                    state_d  = PS_DONE;
                end
            end
            PS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = PS_ERR2;
            end
            PS_ERR2: begin
                hresp   = 1'b1;
                state_d = PS_IDLE;
            end
            default: state_d = PS_IDLE;
        endcase
    end

    // State and captured-transfer registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= PS_IDLE;
            waddr_q  <= '0;
            write_q  <= 1'b0;
            be_q     <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            write_q  <= write_d;
            be_q     <= be_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Request view for the arbiter
    always_comb begin
        hrdata    = hrdata_q;
        req       = (state_q == PS_REQ);
        req_write = write_q;
        req_be    = be_q;
        req_waddr = waddr_q;
    end

endmodule

// File: rtl/ahb_lite_sdram_mport.sv
// Multi-port AHB-Lite front end: round-robin arbitration onto the SDRAM command,
// write-data and read-data FIFOs.
module ahb_lite_sdram_mport
    import ahb_lite_sdram_pkg::*;
#(
    parameter int unsigned PORTS      = 2,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned CMD_WIDTH  = ADDR_WIDTH + 5
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [PORTS-1:0]      HSEL,
    input  logic [32*PORTS-1:0]   HADDR,
    input  logic [2*PORTS-1:0]    HTRANS,
    input  logic [3*PORTS-1:0]    HSIZE,
    input  logic [PORTS-1:0]      HWRITE,
    input  logic [32*PORTS-1:0]   HWDATA,
    input  logic [PORTS-1:0]      HREADY,
    output logic [32*PORTS-1:0]   HRDATA,
    output logic [PORTS-1:0]      HREADYOUT,
    output logic [PORTS-1:0]      HRESP,
    output logic                  CFIFO_WEN,
    output logic [CMD_WIDTH-1:0]  CFIFO_WDATA,
    input  logic                  CFIFO_WFULL,
    output logic                  WFIFO_WEN,
    output logic [31:0]           WFIFO_WDATA,
    input  logic                  WFIFO_WFULL,
    output logic                  RFIFO_REN,
    input  logic [31:0]           RFIFO_RDATA,
    input  logic                  RFIFO_REMPTY
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0]      port_req;
    logic [PORTS-1:0]      port_req_write;
    logic [PORTS-1:0]      port_push;
    logic [PORTS-1:0]      port_pop;
    logic [PORTS-1:0]      port_hreadyout;
    logic [PORTS-1:0]      port_hresp;
    logic [3:0]            port_be    [PORTS];
    logic [ADDR_WIDTH-1:0] port_waddr [PORTS];
    logic [31:0]           port_hrdata[PORTS];

    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         rd_port_q, rd_port_d;
    logic                  rd_busy_q, rd_busy_d;
    logic                  gnt_found;
    logic [PW-1:0]         gnt_idx;
    logic                  gnt_write;
    logic                  push;
    logic                  pop;
    int unsigned           cand;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        ahb_lite_sdram_port #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_port (
            .hclk      (HCLK),
            .hreset    (HRESET),
            .hsel      (HSEL[p]),
            .haddr     (HADDR[32*p +: 32]),
            .htrans    (HTRANS[2*p +: 2]),
            .hsize     (HSIZE[3*p +: 3]),
            .hwrite    (HWRITE[p]),
            .hready    (HREADY[p]),
            .push      (port_push[p]),
            .pop       (port_pop[p]),
            .rdata     (RFIFO_RDATA),
            .hrdata    (port_hrdata[p]),
            .hreadyout (port_hreadyout[p]),
            .hresp     (port_hresp[p]),
            .req       (port_req[p]),
            .req_write (port_req_write[p]),
            .req_be    (port_be[p]),
            .req_waddr (port_waddr[p])
        );
    end

    // Round-robin grant, FIFO push/pop and command mux
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (!gnt_found && port_req[PW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end

        gnt_write = port_req_write[gnt_idx];
        push      = 1'b0;
        // Grants wait while a read is outstanding so read data returns in order
        if (gnt_found && !rd_busy_q) begin
            push = gnt_write ? (!CFIFO_WFULL && !WFIFO_WFULL) : !CFIFO_WFULL;
        end
        pop = rd_busy_q && !RFIFO_REMPTY;

        CFIFO_WEN   = push;
        WFIFO_WEN   = push && gnt_write;
        RFIFO_REN   = pop;
        CFIFO_WDATA = '0;
        CFIFO_WDATA[ADDR_WIDTH-1:0]                      = port_waddr[gnt_idx];
        CFIFO_WDATA[ADDR_WIDTH+CMD_BE_OFS +: CMD_BE_W]   = port_be[gnt_idx];
        CFIFO_WDATA[ADDR_WIDTH+CMD_WRITE_OFS]            = gnt_write;
        WFIFO_WDATA = HWDATA[32*gnt_idx +: 32];

        for (int unsigned p = 0; p < PORTS; p++) begin
            port_push[p] = push && (gnt_idx == PW'(p));
            port_pop[p]  = pop && (rd_port_q == PW'(p));
        end

        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (gnt_idx == PW'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end

        rd_busy_d = rd_busy_q;
        rd_port_d = rd_port_q;
        if (push && !gnt_write) begin
            rd_busy_d = 1'b1;
            rd_port_d = gnt_idx;
        end else if (pop) begin
            rd_busy_d = 1'b0;
        end
    end

    // Arbiter pointer and outstanding-read tracking
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_ptr_q  <= '0;
            rd_port_q <= '0;
            rd_busy_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_port_q <= rd_port_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    // Flatten per-port responses onto the bus vectors
    always_comb begin
        HRDATA    = '0;
        HREADYOUT = port_hreadyout;
        HRESP     = port_hresp;
        for (int unsigned p = 0; p < PORTS; p++) begin
            HRDATA[32*p +: 32] = port_hrdata[p];
        end
    end

endmodule

// File: tb/tb_ahb_lite_sdram_mport.sv
// Directed self-checking bench for ahb_lite_sdram_mport with two ports.
module tb_ahb_lite_sdram_mport;

    localparam int PORTS = 2;
    localparam int AW    = 24;
    localparam int CW    = AW + 5;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [PORTS-1:0]  HSEL;
    logic [32*PORTS-1:0] HADDR;
    logic [2*PORTS-1:0]  HTRANS;
    logic [3*PORTS-1:0]  HSIZE;
    logic [PORTS-1:0]  HWRITE;
    logic [32*PORTS-1:0] HWDATA;
    logic [PORTS-1:0]  HREADY;
    logic [32*PORTS-1:0] HRDATA;
    logic [PORTS-1:0]  HREADYOUT;
    logic [PORTS-1:0]  HRESP;
    logic              CFIFO_WEN;
    logic [CW-1:0]     CFIFO_WDATA;
    logic              CFIFO_WFULL;
    logic              WFIFO_WEN;
    logic [31:0]       WFIFO_WDATA;
    logic              WFIFO_WFULL;
    logic              RFIFO_REN;
    logic [31:0]       RFIFO_RDATA;
    logic              RFIFO_REMPTY;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int ren_cnt = 0;
    int wait_n;
    logic [CW-1:0] cq[$];
    logic [31:0]   wq[$];

    logic [31:0] rd0, rd1;
    int          w0[4], w1[4];
    logic        rw0, rd0r, rw1, rd1r;
    int          waits;
    logic        resp_w, resp_d;
    logic [31:0] rdat;

    always #5 HCLK = ~HCLK;

    // Single-slave buses: each master's HREADY follows its slave's HREADYOUT
    assign HREADY = HREADYOUT;

    ahb_lite_sdram_mport #(
        .PORTS(PORTS),
        .ADDR_WIDTH(AW)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA), .CFIFO_WFULL(CFIFO_WFULL),
        .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA), .WFIFO_WFULL(WFIFO_WFULL),
        .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA), .RFIFO_REMPTY(RFIFO_REMPTY)
    );

    // FIFO-side monitor: log pushes, count pops, flag strobes against full/empty
    always @(posedge HCLK) begin
        if (CFIFO_WEN) cq.push_back(CFIFO_WDATA);
        if (WFIFO_WEN) wq.push_back(WFIFO_WDATA);
        if (RFIFO_REN) ren_cnt++;
        if ((CFIFO_WEN && CFIFO_WFULL) || (WFIFO_WEN && WFIFO_WFULL) || (RFIFO_REN && RFIFO_REMPTY))
            viol++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One AHB transfer on port p; starts and ends on a falling edge with the port ready
    task automatic xfer(input int p, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output int nw,
                        output logic rw, output logic rdn);
        HSEL[p]            = 1'b1;
        HADDR[p*32 +: 32]  = addr;
        HTRANS[p*2 +: 2]   = 2'b10;
        HSIZE[p*3 +: 3]    = size;
        HWRITE[p]          = wr;
        @(negedge HCLK);
        HSEL[p]            = 1'b0;
        HTRANS[p*2 +: 2]   = 2'b00;
        HWDATA[p*32 +: 32] = wd;
        nw = 0;
        rw = 1'b0;
        while (!HREADYOUT[p] && nw < 100) begin
            if (nw == 0) rw = HRESP[p];
            nw++;
            @(negedge HCLK);
        end
        if (!HREADYOUT[p]) check_eq($sformatf("xfer_timeout_p%0d", p), 64'(HREADYOUT[p]), 64'd1);
        rdn = HRESP[p];
        rd  = HRDATA[p*32 +: 32];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; HSEL = '0; HADDR = '0; HTRANS = '0; HSIZE = '0; HWRITE = '0; HWDATA = '0;
        CFIFO_WFULL = 1'b0; WFIFO_WFULL = 1'b0; RFIFO_REMPTY = 1'b1; RFIFO_RDATA = '0;
        repeat (3) @(negedge HCLK);
        check_eq("rst_hreadyout", 64'(HREADYOUT), 64'h3);
        check_eq("rst_hresp",     64'(HRESP), 64'h0);
        check_eq("rst_hrdata",    64'(HRDATA), 64'h0);
        check_eq("rst_strobes",   64'({CFIFO_WEN, WFIFO_WEN, RFIFO_REN}), 64'h0);
        check_eq("rst_rrptr",     64'(dut.rr_ptr_q), 64'h0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Single word write, then a byte write in the top lane
        cq.delete(); wq.delete();
        xfer(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rdat, waits, resp_w, resp_d);
        check_eq("wr_waits", 64'(waits), 64'd1);
        check_eq("wr_resp",  64'(resp_d), 64'd0);
        check_eq("wr_cmd",   64'(cq[0]), 64'h1F000004);
        check_eq("wr_data",  64'(wq[0]), 64'hDEADBEEF);
        xfer(0, 32'h13, 1'b1, 3'd0, 32'hAB000000, rdat, waits, resp_w, resp_d);
        check_eq("wrb_cmd",  64'(cq[1]), 64'h18000004);
        check_eq("wrb_data", 64'(wq[1]), 64'hAB000000);

        // Read on port 1 with data arriving five cycles after the command push
        @(negedge HCLK);
        cq.delete(); wq.delete(); ren_cnt = 0;
        fork
            xfer(1, 32'h20, 1'b0, 3'd2, 32'h0, rdat, waits, resp_w, resp_d);
            begin
                wait_n = 0;
                while (!CFIFO_WEN && wait_n < 50) begin
                    @(negedge HCLK);
                    wait_n++;
                end
                check_eq("rd_push_seen", 64'(CFIFO_WEN), 64'd1);
                repeat (5) @(negedge HCLK);
                RFIFO_RDATA  = 32'h12345678;
                RFIFO_REMPTY = 1'b0;
                @(posedge HCLK);
                @(negedge HCLK);
                RFIFO_REMPTY = 1'b1;
            end
        join
        check_eq("rd_waits",   64'(waits), 64'd6);
        check_eq("rd_data",    64'(rdat), 64'h12345678);
        check_eq("rd_hrdata1", 64'(HRDATA[63:32]), 64'h12345678);
        check_eq("rd_cmd",     64'(cq[0]), 64'h0F000008);
        check_eq("rd_ren_cnt", 64'(ren_cnt), 64'd1);
        check_eq("rd_no_wdata", 64'(wq.size()), 64'd0);

        // Both ports issue four writes starting in the same cycle
        cq.delete(); wq.delete();
        fork
            for (int k = 0; k < 4; k++)
                xfer(0, 32'h100 + 32'(4*k), 1'b1, 3'd2, 32'hA0000000 + 32'(k), rd0, w0[k], rw0, rd0r);
            for (int k = 0; k < 4; k++)
                xfer(1, 32'h202 + 32'(4*k), 1'b1, 3'd1, 32'hB0000000 + 32'(k), rd1, w1[k], rw1, rd1r);
        join
        check_eq("cont_ncmd",  64'(cq.size()), 64'd8);
        check_eq("cont_ndata", 64'(wq.size()), 64'd8);
        check_eq("cont_p1_first_waits", 64'(w1[0]), 64'd2);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("cont_cmd_p0_%0d", k), 64'(cq[2*k]),   64'h1F000040 + 64'(k));
            check_eq($sformatf("cont_cmd_p1_%0d", k), 64'(cq[2*k+1]), 64'h1C000080 + 64'(k));
            check_eq($sformatf("cont_dat_p0_%0d", k), 64'(wq[2*k]),   64'hA0000000 + 64'(k));
            check_eq($sformatf("cont_dat_p1_%0d", k), 64'(wq[2*k+1]), 64'hB0000000 + 64'(k));
        end

        // Command FIFO full for ten cycles during a write
        @(negedge HCLK);
        cq.delete(); wq.delete();
        CFIFO_WFULL = 1'b1;
        fork
            xfer(0, 32'h40, 1'b1, 3'd2, 32'h55AA55AA, rdat, waits, resp_w, resp_d);
            begin
                repeat (10) @(negedge HCLK);
                CFIFO_WFULL = 1'b0;
            end
        join
        check_eq("full_waits", 64'(waits), 64'd10);
        check_eq("full_ncmd",  64'(cq.size()), 64'd1);
        check_eq("full_cmd",   64'(cq[0]), 64'h1F000010);
        check_eq("full_data",  64'(wq[0]), 64'h55AA55AA);

        // Misaligned halfword, then an unsupported size
        @(negedge HCLK);
        cq.delete(); wq.delete();
        xfer(0, 32'h3, 1'b0, 3'd1, 32'h0, rdat, waits, resp_w, resp_d);
        check_eq("err_half_waits", 64'(waits), 64'd1);
        check_eq("err_half_resp1", 64'(resp_w), 64'd1);
        check_eq("err_half_resp2", 64'(resp_d), 64'd1);
        @(negedge HCLK);
        xfer(0, 32'h0, 1'b1, 3'd3, 32'h0, rdat, waits, resp_w, resp_d);
        check_eq("err_size_waits", 64'(waits), 64'd1);
        check_eq("err_size_resp1", 64'(resp_w), 64'd1);
        check_eq("err_size_resp2", 64'(resp_d), 64'd1);
        @(negedge HCLK);
        check_eq("err_idle_resp", 64'(HRESP), 64'd0);
        check_eq("err_no_fifo",   64'(cq.size() + wq.size()), 64'd0);

        // Reset while port 1 waits for read data
        HSEL[1] = 1'b1; HADDR[63:32] = 32'h30; HTRANS[3:2] = 2'b10; HSIZE[5:3] = 3'd2; HWRITE[1] = 1'b0;
        @(negedge HCLK);
        HSEL[1] = 1'b0; HTRANS[3:2] = 2'b00;
        @(negedge HCLK);
        check_eq("rst_rd_rwait",   64'(HREADYOUT[1]), 64'd0);
        check_eq("rst_rd_busy_on", 64'(dut.rd_busy_q), 64'd1);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        check_eq("rst_rd_hready",   64'(HREADYOUT), 64'h3);
        check_eq("rst_rd_busy_off", 64'(dut.rd_busy_q), 64'd0);
        cq.delete(); wq.delete();
        xfer(0, 32'h44, 1'b1, 3'd2, 32'h600DF00D, rdat, waits, resp_w, resp_d);
        check_eq("rst_wr_waits", 64'(waits), 64'd1);
        check_eq("rst_wr_cmd",   64'(cq[0]), 64'h1F000011);
        check_eq("rst_wr_data",  64'(wq[0]), 64'h600DF00D);

        @(negedge HCLK);
        check_eq("fifo_flag_violations", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sdram_mport.md
# ahb_lite_sdram_mport

Multi-port AHB-Lite front end for the SDRAM controller. It arbitrates `PORTS` independent AHB-Lite slave ports onto the write side of the command FIFO and write-data FIFO, and onto the read side of the read-data FIFO. It replaces the single-port bus-to-FIFO adapter in the HCLK domain and adds round-robin arbitration, byte-enable generation and error responses. The clock-domain-crossing FIFOs and the SDRAM engine are unchanged and stay outside this block.

## Interface
Parameters:
- `PORTS`, default 2, number of AHB-Lite slave ports, 1..8.
- `ADDR_WIDTH`, default 24, width of the word address sent to the command FIFO.
- `CMD_WIDTH`, default `ADDR_WIDTH+5`, width of the command word; derived, do not override.

Ports (single clock; reset is synchronous and active-high):
- `HCLK` in 1: bus clock; all logic is on its rising edge.
- `HRESET` in 1: synchronous active-high reset.
- `HSEL` in PORTS: per-port slave select.
- `HADDR` in 32*PORTS: per-port address; port p occupies bits [32p+31:32p].
- `HTRANS` in 2*PORTS: per-port transfer type.
- `HSIZE` in 3*PORTS: per-port transfer size.
- `HWRITE` in PORTS: per-port write flag.
- `HWDATA` in 32*PORTS: per-port write data.
- `HREADY` in PORTS: per-port bus ready.
- `HRDATA` out 32*PORTS: per-port read data.
- `HREADYOUT` out PORTS: per-port ready.
- `HRESP` out PORTS: per-port response; 1 = ERROR.
- `CFIFO_WEN` out 1: push a command word.
- `CFIFO_WDATA` out CMD_WIDTH: command word {write, be[3:0], waddr}.
- `CFIFO_WFULL` in 1: command FIFO full.
- `WFIFO_WEN` out 1: push write data.
- `WFIFO_WDATA` out 32: write data.
- `WFIFO_WFULL` in 1: write-data FIFO full.
- `RFIFO_REN` out 1: pop read data.
- `RFIFO_RDATA` in 32: head of the read-data FIFO; valid while `RFIFO_REMPTY`=0.
- `RFIFO_REMPTY` in 1: read-data FIFO empty.

## Operation
- **Address-phase capture.** A port captures HADDR, HWRITE and HSIZE when HSEL&HREADY&HTRANS[1] (NONSEQ or SEQ).
  - IDLE/BUSY transfers get a zero-wait OKAY.
- **Byte enables.** `be` comes from HSIZE and HADDR[1:0]:
  - byte: `4'b0001<<a`.
  - half: `4'b0011<<a`, legal only if a[0]=0.
  - word: `4'b1111`, legal only if a=0.
- **Illegal transfers.** HSIZE>2 or a misaligned transfer gets a two-cycle ERROR and no FIFO access.
- **Word address.** waddr = HADDR[ADDR_WIDTH+1:2].
- **Per-port FSM.**
  - IDLE → REQ on a valid capture; IDLE → ERR1 on an illegal capture.
  - REQ: HREADYOUT=0; request is visible to the arbiter.
  - REQ, granted write with !CFIFO_WFULL&!WFIFO_WFULL: CFIFO_WEN=WFIFO_WEN=1 this cycle, WFIFO_WDATA = that port's HWDATA, → DONE.
  - REQ, granted read with !CFIFO_WFULL: CFIFO_WEN=1, → RWAIT.
  - RWAIT: HREADYOUT=0. When !RFIFO_REMPTY: RFIFO_REN=1, HRDATA<=RFIFO_RDATA, → DONE.
  - DONE: HREADYOUT=1, HRESP=0. → REQ or ERR1 if a new transfer is captured this cycle, else → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, → IDLE.
- **Arbiter.**
  - Round-robin over ports in REQ. The pointer advances to grant+1 after each FIFO push.
  - Grant is combinational and is given only when no read is outstanding (global `rd_busy` flag).
  - A read holds `rd_busy` from its CFIFO push until its RFIFO pop, so read data is returned in order.
  - Writes stay posted while no read is outstanding.
- **Outputs.** CFIFO_WEN, WFIFO_WEN and RFIFO_REN are never asserted while the matching full/empty flag forbids it. RFIFO_REN is never asserted when `rd_busy`=0.
- **Reset.**
  - Reset mid-operation returns every FSM to IDLE and clears `rd_busy`.
  - Reset must coincide with the FIFO resets; stale read data is not tracked.

## Timing
- **Reset values:** HREADYOUT all 1, HRESP all 0, HRDATA all 0, FIFO strobes 0, RR pointer 0.
- **Write latency:** 1 wait state when granted with the FIFOs non-full (data phase D1 push, D2 ready). Each additional wait state comes from contention or a full FIFO.
- **Read latency:** push in D1, then at least 1 cycle in RWAIT for the pop, then DONE. Minimum is 2 wait states plus the SDRAM round trip.
- **Simultaneous requests:** only one port is granted per cycle. The others stay in REQ with HREADYOUT=0.
- **Full flag in the grant cycle:** no push, the pointer is unchanged, and re-arbitration happens next cycle.

## Structure
- Package `ahb_lite_sdram_pkg`:
  - HTRANS/HSIZE constants.
  - Command-word field offsets.
  - Port FSM state encoding.
  - `be` helper function.
- Sub-module `ahb_lite_sdram_port`: one per port (FSM, capture, HRDATA register), generated PORTS times.
- The arbiter and FIFO mux live in the top module.

## Test plan
- **Single write.** Port 0 writes 0xDEADBEEF to 0x00000010 → CFIFO word {1,4'hF,24'h4}, WFIFO 0xDEADBEEF, HREADYOUT low 1 cycle.
- **Read return.** Port 1 reads 0x20, RFIFO supplies 0x12345678 after 5 cycles → HRDATA[63:32]=0x12345678 in the DONE cycle, exactly one REN pulse.
- **Contention.** Both ports write in the same cycle for 4 transfers each → pushes alternate p0,p1,p0,p1…, no lost transfers.
- **Full stall.** CFIFO_WFULL=1 for 10 cycles during a write → no WEN, HREADYOUT=0 throughout, completes 1 cycle after full drops.
- **Error response.** Misaligned halfword at 0x3, then HSIZE=3 → two-cycle ERROR each (HREADYOUT 0→1 with HRESP=1), no FIFO activity.
- **Reset mid-read.** HRESET asserted while a port is in RWAIT → next cycle all HREADYOUT=1, rd_busy=0, a new write is granted immediately.
